// File: rtl/cc_pkg.sv
// Shared definitions for the condition-code register and its save/restore stack.
package cc_pkg;

    localparam int unsigned CC_C      = 0;
    localparam int unsigned CC_Z      = 1;
    localparam int unsigned CC_N      = 2;
    localparam int unsigned CC_V      = 3;
    localparam int unsigned CC_FLAG_W = 4;

endpackage : cc_pkg

// File: rtl/cc_lifo.sv
// Register-array LIFO holding saved condition codes; exposes the top entry and a depth count.
module cc_lifo #(
    parameter  int unsigned W       = 4,
    parameter  int unsigned DEPTH   = 4,
    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [W-1:0]       din,
    output logic [W-1:0]       top_c,
    output logic [DEPTH_W-1:0] depth,
    output logic               full_c,
    output logic               empty_c
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]       mem [DEPTH];
    logic [IDX_W-1:0]   wr_idx_c;
    logic [IDX_W-1:0]   rd_idx_c;

    assign full_c   = (depth == DEPTH_W'(DEPTH));
    assign empty_c  = (depth == '0);
    assign wr_idx_c = IDX_W'(depth);
    assign rd_idx_c = IDX_W'(depth - DEPTH_W'(1));
    assign top_c    = empty_c ? '0 : mem[rd_idx_c];

    // Depth saturates at both ends; push/pop against the limit is ignored here.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth <= '0;
        end else if (push && !full_c) begin
            depth <= depth + DEPTH_W'(1);
        end else if (pop && !empty_c) begin
            depth <= depth - DEPTH_W'(1);
        end
    end

    // Entries are not reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push && !full_c) begin
            mem[wr_idx_c] <= din;
        end
    end

endmodule : cc_lifo

// File: rtl/cc_flag_stack.sv
// Condition-code register with masked ALU update and a save/restore stack for nested interrupts.
// Optional move-to-CC write port enabled by defining CC_SW_WRITE_EN.
module cc_flag_stack
    import cc_pkg::*;
#(
    parameter  int unsigned FLAG_W  = CC_FLAG_W,
    parameter  int unsigned DEPTH   = 4,
    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLAG_W-1:0]  alu_flags,
    input  logic [FLAG_W-1:0]  alu_we,
    input  logic               int_entry,
    input  logic               reti,
    input  logic               err_clr,
`ifdef CC_SW_WRITE_EN
    input  logic               sw_we,
    input  logic [FLAG_W-1:0]  sw_flags,
`endif
    output logic [FLAG_W-1:0]  cc_flags,
    output logic [DEPTH_W-1:0] cc_depth,
    output logic               cc_ovf_err,
    output logic               cc_unf_err
);

    logic [FLAG_W-1:0] nxt_c;
    logic [FLAG_W-1:0] flags_d_c;
    logic [FLAG_W-1:0] top_c;
    logic              full_c;
    logic              empty_c;
    logic              restore_c;
    logic              push_c;
    logic              pop_c;
    logic              ovf_ev_c;
    logic              unf_ev_c;

    cc_lifo #(
        .W     (FLAG_W),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_c),
        .pop     (pop_c),
        .din     (nxt_c),
        .top_c   (top_c),
        .depth   (cc_depth),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // A restore (reti with saved context) overrides any flag update; a tail-chain
    // (reti + int_entry) restores without touching the stack.
    always_comb begin
        nxt_c = (cc_flags & ~alu_we) | (alu_flags & alu_we);
`ifdef CC_SW_WRITE_EN
        if (sw_we) begin
            nxt_c = sw_flags;
        end
`endif
        restore_c = reti & ~empty_c;
        push_c    = int_entry & ~restore_c & ~full_c;
        pop_c     = restore_c & ~int_entry;
        ovf_ev_c  = int_entry & ~restore_c & full_c;
        unf_ev_c  = reti & ~int_entry & empty_c;
        flags_d_c = restore_c ? top_c : nxt_c;
    end

    // Error events win over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cc_flags   <= '0;
            cc_ovf_err <= 1'b0;
            cc_unf_err <= 1'b0;
        end else begin
            cc_flags   <= flags_d_c;
            cc_ovf_err <= ovf_ev_c | (cc_ovf_err & ~err_clr);
            cc_unf_err <= unf_ev_c | (cc_unf_err & ~err_clr);
        end
    end

endmodule : cc_flag_stack

// File: tb/tb_cc_flag_stack.sv
// Scoreboard bench for cc_flag_stack: driver updates a queue-based model, monitor compares registered outputs.
module tb_cc_flag_stack;

    localparam int unsigned W       = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [W-1:0]       flags;
        logic [DEPTH_W-1:0] depth;
        logic               ovf;
        logic               unf;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [W-1:0]       alu_flags = '0;
    logic [W-1:0]       alu_we = '0;
    logic               int_entry = 1'b0;
    logic               reti = 1'b0;
    logic               err_clr = 1'b0;
    logic               sw_we = 1'b0;
    logic [W-1:0]       sw_flags = '0;
    logic [W-1:0]       cc_flags;
    logic [DEPTH_W-1:0] cc_depth;
    logic               cc_ovf_err;
    logic               cc_unf_err;

    int n_vec = 0;
    int n_bad = 0;

    exp_t         exp_q[$];
    logic [W-1:0] m_stack[$];
    logic [W-1:0] m_flags = '0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    cc_flag_stack #(
        .FLAG_W (W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_flags  (alu_flags),
        .alu_we     (alu_we),
        .int_entry  (int_entry),
        .reti       (reti),
        .err_clr    (err_clr),
`ifdef CC_SW_WRITE_EN
        .sw_we      (sw_we),
        .sw_flags   (sw_flags),
`endif
        .cc_flags   (cc_flags),
        .cc_depth   (cc_depth),
        .cc_ovf_err (cc_ovf_err),
        .cc_unf_err (cc_unf_err)
    );

    always #5 clk = ~clk;

    // Reference model: stack kept as a queue, applied once per cycle of stimulus.
    task automatic model_step();
        logic [W-1:0] nxt;
        int           d;
        logic         ovf_ev;
        logic         unf_ev;
        exp_t         e;
        nxt = (m_flags & ~alu_we) | (alu_flags & alu_we);
`ifdef CC_SW_WRITE_EN
        if (sw_we) nxt = sw_flags;
`endif
        if (reset) begin
            m_flags = '0;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            d = m_stack.size();
            ovf_ev = 1'b0;
            unf_ev = 1'b0;
            if (reti && d > 0) begin
                m_flags = m_stack[d-1];
                if (!int_entry) void'(m_stack.pop_back());
            end else if (int_entry) begin
                if (d < int'(DEPTH)) m_stack.push_back(nxt);
                else ovf_ev = 1'b1;
                m_flags = nxt;
            end else begin
                if (reti) unf_ev = 1'b1;
                m_flags = nxt;
            end
            m_ovf = ovf_ev | (m_ovf & ~err_clr);
            m_unf = unf_ev | (m_unf & ~err_clr);
        end
        e.flags = m_flags;
        e.depth = DEPTH_W'(m_stack.size());
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [W-1:0] af, input logic [W-1:0] we,
                         input logic ie, input logic rt, input logic clr, input logic rst);
        @(negedge clk);
        alu_flags = af;
        alu_we    = we;
        int_entry = ie;
        reti      = rt;
        err_clr   = clr;
        reset     = rst;
        model_step();
    endtask

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: each posedge retires exactly one queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cc_flags",   int'(cc_flags),   int'(e.flags));
            check("cc_depth",   int'(cc_depth),   int'(e.depth));
            check("cc_ovf_err", int'(cc_ovf_err), int'(e.ovf));
            check("cc_unf_err", int'(cc_unf_err), int'(e.unf));
        end
    end

    initial begin
        drive(4'h0, 4'h0, 0, 0, 0, 1);
        // Masked update and hold
        drive(4'hF, 4'b0101, 0, 0, 0, 0);
        drive(4'hA, 4'h0, 0, 0, 0, 0);
        drive(4'h0, 4'h0, 0, 0, 0, 0);
        // Push includes retiring update, restore ignores ALU
        drive(4'b0011, 4'hF, 0, 0, 0, 0);
        drive(4'h0, 4'b0001, 1, 0, 0, 0);
        drive(4'h0, 4'hF, 0, 0, 0, 0);
        drive(4'hF, 4'hF, 0, 1, 0, 0);
        // Fill, overflow, drain
        for (int v = 1; v <= int'(DEPTH); v++) drive(W'(v), 4'hF, 1, 0, 0, 0);
        drive(4'h0, 4'h0, 1, 0, 0, 0);
        for (int i = 0; i < int'(DEPTH); i++) drive(4'hC, 4'hF, 0, 1, 0, 0);
        drive(4'h0, 4'h0, 0, 0, 1, 0);
        // Underflow, clear, event-vs-clear priority
        drive(4'b1000, 4'hF, 0, 1, 0, 0);
        drive(4'h0, 4'h0, 0, 0, 1, 0);
        drive(4'h0, 4'h0, 0, 1, 1, 0);
        drive(4'h0, 4'h0, 0, 0, 1, 0);
        // Tail-chain at depth 2, then at depth 0
        drive(4'b0101, 4'hF, 1, 0, 0, 0);
        drive(4'b0110, 4'hF, 1, 0, 0, 0);
        drive(4'h0, 4'hF, 0, 0, 0, 0);
        drive(4'h9, 4'hF, 1, 1, 0, 0);
        drive(4'h0, 4'h0, 0, 1, 0, 0);
        drive(4'h0, 4'h0, 0, 1, 0, 0);
        drive(4'h3, 4'hF, 1, 1, 0, 0);
        // Reset mid-nesting
        drive(4'h7, 4'hF, 1, 0, 0, 0);
        drive(4'h1, 4'hF, 1, 0, 0, 0);
        drive(4'h0, 4'h0, 1, 0, 0, 0);
        drive(4'h0, 4'h0, 0, 1, 0, 0);
        drive(4'hF, 4'hF, 1, 1, 0, 1);
`ifdef CC_SW_WRITE_EN
        @(negedge clk);
        sw_we = 1'b1; sw_flags = 4'b1001;
        alu_flags = 4'h6; alu_we = 4'hF; int_entry = 1'b1; reti = 1'b0; err_clr = 1'b0; reset = 1'b0;
        model_step();
        @(negedge clk);
        sw_flags = 4'b0100; int_entry = 1'b0; reti = 1'b1;
        model_step();
        @(negedge clk);
        sw_we = 1'b0; reti = 1'b0;
        model_step();
`endif
        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] af;
            logic [W-1:0] we;
            af = W'($urandom);
            we = W'($urandom);
`ifdef CC_SW_WRITE_EN
            @(negedge clk);
            sw_we = ($urandom_range(0, 9) == 0);
            sw_flags = W'($urandom);
            alu_flags = af; alu_we = we;
            int_entry = ($urandom_range(0, 3) == 0);
            reti = ($urandom_range(0, 3) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 63) == 0);
            model_step();
`else
            drive(af, we, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
`endif
        end
        @(negedge clk);
        int_entry = 1'b0; reti = 1'b0; err_clr = 1'b0; alu_we = '0; sw_we = 1'b0;
        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_cc_flag_stack
